// File: rtl/vu_pkg.sv
// Shared types and constants for the VU meter frame scheduler.
package vu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_ARM,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } vu_state_e;

  localparam int ACK_TIMEOUT = 16;

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ACK_CNT_W = cnt_width(ACK_TIMEOUT);

endpackage

// File: rtl/vu_frame_timer.sv
// Free-running frame counter; o_tick marks the last clock of every frame.
module vu_frame_timer
  import vu_pkg::*;
#(
  parameter int FRAME_CLKS = 800000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = cnt_width(FRAME_CLKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);
  assign cnt_d  = o_tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vu_frame_scheduler.sv
// Per-frame peak capture, bar scaling/decay and NeoPixel send handshake.
// Optional peak hold is built when VU_PEAK_HOLD_EN is defined.
module vu_frame_scheduler
  import vu_pkg::*;
#(
  parameter int LEDS        = 20,
  parameter int ADDR        = 8,
  parameter int LEVEL_W     = 12,
  parameter int FRAME_CLKS  = 800000,
  parameter int DECAY_STEP  = 1,
  parameter int HOLD_FRAMES = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sample_valid,
  input  logic [LEVEL_W-1:0] i_sample,
  input  logic               i_rdy,
  output logic               o_send,
  output logic [ADDR-1:0]    o_value,
  output logic               o_overrun,
  output logic               o_busy
);

  localparam int PROD_W = LEVEL_W + ADDR;
  localparam logic [ADDR-1:0] LEDS_V    = ADDR'(LEDS);
  localparam logic [ADDR-1:0] STEP_V    = ADDR'(DECAY_STEP);
  localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);

  if (LEDS >= (1 << ADDR) || HOLD_FRAMES < 0) begin : g_cfg_err
    $error("vu_frame_scheduler: LEDS must fit in ADDR bits and HOLD_FRAMES must be >= 0");
  end

  logic tick;

  vu_frame_timer #(.FRAME_CLKS(FRAME_CLKS)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  // Peak accumulator; a sample landing on the tick opens the next frame.
  logic [LEVEL_W-1:0] acc_q, acc_d, peak_q, peak_d;

  always_comb begin
    acc_d  = acc_q;
    peak_d = peak_q;
    if (tick) begin
      peak_d = acc_q;
      acc_d  = i_sample_valid ? i_sample : '0;
    end else if (i_sample_valid && (i_sample > acc_q)) begin
      acc_d = i_sample;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      peak_q <= '0;
    end else begin
      acc_q  <= acc_d;
      peak_q <= peak_d;
    end
  end

  logic [PROD_W-1:0] prod, scaled;
  logic [ADDR-1:0]   target;

  assign prod   = PROD_W'(peak_q) * PROD_W'(LEDS + 1);
  assign scaled = prod >> LEVEL_W;
  assign target = (scaled > PROD_W'(LEDS)) ? LEDS_V : scaled[ADDR-1:0];

  vu_state_e       state_q;
  logic [ADDR-1:0] disp_q, disp_d, decayed;

  assign decayed = (disp_q > STEP_V) ? (disp_q - STEP_V) : '0;

`ifdef VU_PEAK_HOLD_EN
  localparam int HOLD_W = cnt_width(HOLD_FRAMES + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    disp_d = disp_q;
    hold_d = hold_q;
    if (target > disp_q) begin
      disp_d = target;
      hold_d = HOLD_W'(HOLD_FRAMES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else begin
      disp_d = (target > decayed) ? target : decayed;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                   hold_q <= '0;
    else if (state_q == ST_UPDATE)  hold_q <= hold_d;
  end
`else
  always_comb begin
    disp_d = disp_q;
    if (target >= disp_q)     disp_d = target;
    else if (target > decayed) disp_d = target;
    else                       disp_d = decayed;
  end
`endif

  logic [ACK_CNT_W-1:0] ack_cnt_q;
  logic                 send_q, busy_q;
  logic [ADDR-1:0]      value_q;

  // A tick caught in ARM has not been sent yet, so it is refreshed with the newest peak.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      ack_cnt_q <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      value_q   <= '0;
      disp_q    <= '0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_UPDATE;
            busy_q  <= 1'b1;
          end
        end
        ST_UPDATE: begin
          disp_q  <= disp_d;
          value_q <= disp_d;
          if (i_rdy) begin
            state_q <= ST_SEND;
            send_q  <= 1'b1;
          end else begin
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (tick) begin
            state_q <= ST_UPDATE;
          end else if (i_rdy) begin
            state_q <= ST_SEND;
            send_q  <= 1'b1;
          end
        end
        ST_SEND: begin
          state_q   <= ST_WAIT_ACK;
          ack_cnt_q <= ACK_CNT_W'(1);
        end
        ST_WAIT_ACK: begin
          if (!i_rdy) begin
            state_q <= ST_WAIT_DONE;
          end else if (ack_cnt_q == ACK_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (i_rdy) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_send    = send_q;
  assign o_value   = value_q;
  assign o_busy    = busy_q;
  assign o_overrun = i_rst_n & tick & (state_q != ST_IDLE);

endmodule

// File: tb/tb_vu_frame_scheduler.sv
// Randomized bench for vu_frame_scheduler against a frame-level reference model.
module tb_vu_frame_scheduler;

  localparam int LEDS = 20, ADDR = 8, LEVEL_W = 12, FC = 100, STEP = 2, HOLD = 3;
  localparam int ACK_TO = 16;

  typedef enum int {STUB_NORMAL, STUB_STUCK, STUB_LOW} stub_e;

  logic               clk = 1'b0, rst_n = 1'b0, sv = 1'b0, rdy = 1'b1;
  logic [LEVEL_W-1:0] smp_in = '0;
  logic               send, overrun, busy;
  logic [ADDR-1:0]    value;

  int n_chk = 0, n_fail = 0;

  int    c, smp_q[$];
  int    m_disp, m_hold, exp_val, pend_val, send_due, stuck_s;
  int    drop_at, rise_at, ftype;
  bit    gen;
  stub_e stub_mode;
  int    obs_c;
  logic  obs_send, obs_ovr, obs_busy;
  logic [ADDR-1:0] obs_value;

  always #5 clk = ~clk;

  vu_frame_scheduler #(
    .LEDS(LEDS), .ADDR(ADDR), .LEVEL_W(LEVEL_W), .FRAME_CLKS(FC),
    .DECAY_STEP(STEP), .HOLD_FRAMES(HOLD)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv), .i_sample(smp_in),
    .i_rdy(rdy), .o_send(send), .o_value(value), .o_overrun(overrun), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, c, got, exp);
    end
  endtask

  // Largest sample in frame f: cycles from the previous tick cycle up to the one before this tick.
  function automatic int frame_peak(input int f);
    int lo = (f == 0) ? 0 : FC * f - 1;
    int hi = FC * f + FC - 2;
    int m  = 0;
    for (int k = lo; k <= hi; k++) if (smp_q[k] > m) m = smp_q[k];
    return m;
  endfunction

  function automatic int bar_of(input int peak);
    int t = (peak * (LEDS + 1)) / (1 << LEVEL_W);
    return (t > LEDS) ? LEDS : t;
  endfunction

  task automatic model_frame(input int peak);
    int t = bar_of(peak);
    int fall = (m_disp - STEP < 0) ? 0 : m_disp - STEP;
`ifdef VU_PEAK_HOLD_EN
    if (t > m_disp) begin
      m_disp = t;
      m_hold = HOLD;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      m_disp = (t > fall) ? t : fall;
    end
`else
    m_disp = (t >= m_disp) ? t : ((t > fall) ? t : fall);
`endif
  endtask

  function automatic int rand_sample(input int ft);
    case (ft)
      0:       return -1;
      1:       return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : -1;
      default: return ($urandom_range(0, 49) == 0) ? int'($urandom_range(3000, 4095)) : -1;
    endcase
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    rdy   = 1'b1;
    for (int i = 0; i < n; i++) begin
      sv     = 1'($urandom_range(0, 1));
      smp_in = LEVEL_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("rst_send", send, 1'b0);
      chk("rst_value", value, '0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    c = 0;
    smp_q.delete();
    m_disp = 0; m_hold = 0; exp_val = 0; pend_val = 0;
    send_due = -1; stuck_s = -1; drop_at = -1; rise_at = -1;
  endtask

  // One clock: observe outputs of cycle c, update model and stub, drive inputs, advance.
  task automatic step(input int s);
    bit tick_now;
    obs_c = c; obs_send = send; obs_value = value; obs_ovr = overrun; obs_busy = busy;
    tick_now = (c % FC) == FC - 1;
    if (obs_send) chk("send_while_rdy_low", rdy, 1'b1);
    if (gen) begin
      if (c == send_due) exp_val = pend_val;
      chk("send_strobe", obs_send, 32'(c == send_due));
      chk("value", obs_value, exp_val);
      chk("overrun", obs_ovr, 1'b0);
      if (tick_now) chk("idle_at_tick", obs_busy, 1'b0);
      if (c == send_due - 1) chk("busy_in_update", obs_busy, 1'b1);
      if (stuck_s >= 0 && c == stuck_s + ACK_TO - 1) chk("busy_before_timeout", obs_busy, 1'b1);
      if (stuck_s >= 0 && c == stuck_s + ACK_TO) chk("idle_after_timeout", obs_busy, 1'b0);
    end
    if (tick_now) begin
      model_frame(frame_peak(c / FC));
      pend_val = m_disp;
      send_due = c + 2;
    end
    case (stub_mode)
      STUB_LOW:   rdy = 1'b0;
      STUB_STUCK: begin
        rdy = 1'b1;
        if (obs_send) stuck_s = c;
      end
      default: begin
        if (obs_send) begin
          drop_at = c + int'($urandom_range(1, 3));
          rise_at = drop_at + int'($urandom_range(1, 6));
        end
        rdy = !(c >= drop_at && c < rise_at);
      end
    endcase
    sv     = (s >= 0);
    smp_in = (s >= 0) ? LEVEL_W'(s) : '0;
    smp_q.push_back((s >= 0) ? s : 0);
    @(posedge clk);
    c++;
    @(negedge clk);
  endtask

  initial begin
    int s, n_send, n_early, n_ovr, ovr_c, last_val;
    stub_mode = STUB_NORMAL;
    gen = 1'b1;
    c = 0;
    @(negedge clk);
    do_reset(5);

    // Directed frames, then random frames, a stuck-ready frame, and a mid-handshake reset.
    while (c < 2803) begin
      if (c < 1600) begin
        s = (c == 30) ? 2048 : (c == 130 || c == 1499) ? 4095 : -1;
      end else begin
        if (c % FC == 0) ftype = int'($urandom_range(0, 2));
        s = rand_sample(ftype);
      end
      if (c == 2600) stub_mode = STUB_STUCK;
      if (c == 2750) stub_mode = STUB_NORMAL;
      step(s);
    end

    gen = 1'b0;
    do_reset(3);
    stub_mode = STUB_LOW;
    n_send = 0; n_early = 0; n_ovr = 0; ovr_c = -1; last_val = -1;
    while (c < 260) begin
      if (c == 210) stub_mode = STUB_NORMAL;
      step((c == 10) ? 1000 : (c == 150) ? 4095 : -1);
      if (obs_send) begin
        n_send++;
        last_val = int'(obs_value);
        if (obs_c < 211) n_early++;
      end
      if (obs_ovr) begin
        n_ovr++;
        ovr_c = obs_c;
      end
    end
    chk("overrun_pulses", n_ovr, 1);
    chk("overrun_cycle", ovr_c, 199);
    chk("send_before_rdy", n_early, 0);
    chk("send_count_after_rdy", n_send, 1);
    chk("send_value_newest", last_val, LEDS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
